// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the o_overflow signal to the bundle.
interface serial_subtractor_if #(
  parameter int N = 32
);
  logic         i_start;
  logic [N-1:0] i_minuend;
  logic [N-1:0] i_subtrahend;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_diff;
  logic         o_borrow;
  logic         o_zero;
`ifdef SERIAL_SUB_OVF_EN
  logic         o_overflow;
`endif

  modport master (
    output i_start, i_minuend, i_subtrahend,
    input  o_busy, o_done, o_diff, o_borrow, o_zero
`ifdef SERIAL_SUB_OVF_EN
    , input o_overflow
`endif
  );

  modport slave (
    input  i_start, i_minuend, i_subtrahend,
    output o_busy, o_done, o_diff, o_borrow, o_zero
`ifdef SERIAL_SUB_OVF_EN
    , output o_overflow
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B, one bit per clock through a single borrow flop.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output.
module serial_subtractor #(
  parameter int N = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, r_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  diff_q;
  logic          borrow_q, zero_q, done_q;
`ifdef SERIAL_SUB_OVF_EN
  logic          a_msb_q, b_msb_q, ovf_q;
`endif

  logic         a0, b0, d_bit, br_d;
  logic [N-1:0] r_d;

  // One full-subtractor stage; the difference bit enters the result MSB.
  assign a0    = a_q[0];
  assign b0    = b_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;
  assign br_d  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign r_d   = {d_bit, r_q[N-1:1]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the datapath registers are reset as well, so a reset mid-operation
      // leaves no partial result behind.
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.i_start) begin
            a_q     <= bus.i_minuend;
            b_q     <= bus.i_subtrahend;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= bus.i_minuend[N-1];
            b_msb_q <= bus.i_subtrahend[N-1];
`endif
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            diff_q   <= r_d;
            borrow_q <= br_d;
            zero_q   <= (r_d == '0);
            done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= (a_msb_q != b_msb_q) && (r_d[N-1] != a_msb_q);
`endif
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_busy   = (state_q == SHIFT);
  assign bus.o_done   = done_q;
  assign bus.o_diff   = diff_q;
  assign bus.o_borrow = borrow_q;
  assign bus.o_zero   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.o_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at N=8 and N=32.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last8 = 8'h00;

  always #5 clk = ~clk;

  serial_subtractor_if #(.N(8))  bus8 ();
  serial_subtractor_if #(.N(32)) bus32 ();

  serial_subtractor #(.N(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
  serial_subtractor #(.N(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation; repulse>0 re-asserts start with other operands mid-SHIFT.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_d, input logic exp_b, input logic exp_z,
                     input logic exp_v, input int repulse);
    bus8.i_minuend    = a;
    bus8.i_subtrahend = b;
    bus8.i_start      = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    check({tag, "_busy_k"}, 32'(bus8.o_busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, "_busy"}, 32'(bus8.o_busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus8.o_done), 32'd0);
      check({tag, "_hold"}, 32'(bus8.o_diff), 32'(last8));
      if (repulse != 0 && i == repulse) begin
        bus8.i_start      = 1'b1;
        bus8.i_minuend    = 8'h00;
        bus8.i_subtrahend = 8'h55;
      end else if (repulse != 0 && i == repulse + 1) begin
        bus8.i_start = 1'b0;
      end
    end
    tick();
    check({tag, "_done"}, 32'(bus8.o_done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus8.o_busy), 32'd0);
    check({tag, "_diff"}, 32'(bus8.o_diff), 32'(exp_d));
    check({tag, "_borrow"}, 32'(bus8.o_borrow), 32'(exp_b));
    check({tag, "_zero"}, 32'(bus8.o_zero), 32'(exp_z));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(bus8.o_overflow), 32'(exp_v));
`else
    if (exp_v !== exp_v) $display("unreachable");
`endif
    last8 = exp_d;
    tick();
    check({tag, "_done_clr"}, 32'(bus8.o_done), 32'd0);
    check({tag, "_idle"}, 32'(bus8.o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus8.i_start       = 1'b0;
    bus8.i_minuend     = '0;
    bus8.i_subtrahend  = '0;
    bus32.i_start      = 1'b0;
    bus32.i_minuend    = '0;
    bus32.i_subtrahend = '0;

    // Reset state, then 20 quiet cycles.
    repeat (3) tick();
    check("rst_busy8", 32'(bus8.o_busy), 32'd0);
    check("rst_done8", 32'(bus8.o_done), 32'd0);
    check("rst_diff8", 32'(bus8.o_diff), 32'd0);
    check("rst_zero8", 32'(bus8.o_zero), 32'd0);
    check("rst_diff32", bus32.o_diff, 32'd0);
    check("rst_busy32", 32'(bus32.o_busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", 32'(bus8.o_busy), 32'd0);
      check("idle_done", 32'(bus8.o_done), 32'd0);
    end
    check("idle_diff", 32'(bus8.o_diff), 32'd0);
    check("idle_borrow", 32'(bus8.o_borrow), 32'd0);
    check("idle_zero", 32'(bus8.o_zero), 32'd0);

    op8("sub5a23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0, 0);
    op8("sub1020", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 0);
    op8("sub8001", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 0);
    op8("repulse", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 3);

    // Back-to-back N=32 operations with start held through DONE.
    bus32.i_minuend    = 32'd4565;
    bus32.i_subtrahend = 32'd1209;
    bus32.i_start      = 1'b1;
    tick();
    check("b2b_busy_k", 32'(bus32.o_busy), 32'd1);
    bus32.i_minuend    = 32'd7;
    bus32.i_subtrahend = 32'd7;
    repeat (31) tick();
    check("b2b_busy_k31", 32'(bus32.o_busy), 32'd1);
    check("b2b_nodone_k31", 32'(bus32.o_done), 32'd0);
    tick();
    check("b2b_done1", 32'(bus32.o_done), 32'd1);
    check("b2b_diff1", bus32.o_diff, 32'd3356);
    check("b2b_borrow1", 32'(bus32.o_borrow), 32'd0);
    check("b2b_zero1", 32'(bus32.o_zero), 32'd0);
    tick();
    check("b2b_restart", 32'(bus32.o_busy), 32'd1);
    check("b2b_done_clr", 32'(bus32.o_done), 32'd0);
    check("b2b_hold", bus32.o_diff, 32'd3356);
    repeat (31) tick();
    check("b2b_nodone_k64", 32'(bus32.o_done), 32'd0);
    tick();
    bus32.i_start = 1'b0;
    check("b2b_done2", 32'(bus32.o_done), 32'd1);
    check("b2b_diff2", bus32.o_diff, 32'd0);
    check("b2b_zero2", 32'(bus32.o_zero), 32'd1);
    check("b2b_borrow2", 32'(bus32.o_borrow), 32'd0);
    tick();
    check("b2b_idle", 32'(bus32.o_busy), 32'd0);
    check("b2b_done2_clr", 32'(bus32.o_done), 32'd0);

    // Reset mid-operation at k+4.
    bus8.i_minuend    = 8'h5A;
    bus8.i_subtrahend = 8'h23;
    bus8.i_start      = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(bus8.o_busy), 32'd0);
    check("mrst_diff", 32'(bus8.o_diff), 32'd0);
    check("mrst_borrow", 32'(bus8.o_borrow), 32'd0);
    check("mrst_zero", 32'(bus8.o_zero), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("mrst_ovf", 32'(bus8.o_overflow), 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_nodone", 32'(bus8.o_done), 32'd0);
    end
    rst   = 1'b0;
    last8 = 8'h00;
    op8("post_rst", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B one bit per clock through a single registered full-subtractor stage, with a start/done handshake. It complements the combinational adder library: it trades N-bit ripple logic for one borrow flop and a counter, and serves as the area-minimal difference/compare engine in front of datapaths fed by `N_bit_adder`-style units.

## Interface
- `N`, default 32: operand and result width, ≥2.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  request; sampled only when accepting (IDLE or DONE).
- `i_minuend`  in  N  A; captured on accepted start.
- `i_subtrahend`  in  N  B; captured on accepted start.
- `o_busy`  out  1  high while in SHIFT.
- `o_done`  out  1  one-cycle pulse; result valid.
- `o_diff`  out  N  A − B mod 2^N; held until the next completion.
- `o_borrow`  out  1  final borrow; 1 iff A < B unsigned.
- `o_zero`  out  1  1 iff o_diff == 0.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE; all outputs 0; internal registers 0.
- IDLE/DONE + i_start=1 → capture A, B into shift registers, borrow flop ← 0, bit counter ← 0, → SHIFT.
- DONE + i_start=0 → IDLE. IDLE + i_start=0 → stay.
- SHIFT, per cycle: d = a0 ^ b0 ^ br; br' = (~a0 & b0) | (~(a0 ^ b0) & br). d shifts into the result register MSB; A and B shift right; counter +1.
- SHIFT with counter == N−1: process the last bit, then in the same edge load o_diff ← final result, o_borrow ← br', o_zero ← (result == 0), o_done ← 1, → DONE.
- i_start during SHIFT is ignored; operand inputs may change freely while SHIFT is active.
- o_diff, o_borrow and o_zero do not change during SHIFT; they show the previous result.
- Arithmetic is unsigned modulo 2^N; no carry-in port; initial borrow is 0.

## Timing
- Start accepted at edge k: o_busy=1 from k to k+N (N cycles).
- Bits 0..N−1 are processed at edges k+1..k+N. Outputs update and o_done rises at edge k+N, with o_busy falling at the same edge.
- o_done stays high exactly one cycle and clears at edge k+N+1.
- Throughput: if i_start=1 in the DONE cycle, the next operation starts at k+N+1 with no idle gap, giving one result every N+1 cycles.
- Reset asserted mid-operation: outputs clear immediately (asynchronously), → IDLE, and the partial result is discarded. The first start is accepted at the first edge after release.

## Configuration
- `SERIAL_SUB_OVF_EN` defined: adds port `o_overflow` (out, 1) for signed two's-complement overflow.
  - o_overflow = (A[N−1] ≠ B[N−1]) & (D[N−1] ≠ A[N−1]).
  - Captured MSBs are kept for this calculation.
  - o_overflow updates with o_diff and resets to 0.
- Not defined: no port and no extra registers; behaviour is otherwise identical.

## Test plan
- Reset held, then released, with i_start=0 → all outputs 0, o_busy=0, state IDLE for 20 cycles.
- N=8, A=0x5A, B=0x23, single start → o_busy high for 8 cycles; o_done one-cycle pulse at edge k+8; o_diff=0x37, o_borrow=0, o_zero=0.
- N=8, A=0x10, B=0x20 → o_diff=0xF0, o_borrow=1. With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 → o_diff=0x7F, o_overflow=1.
- N=32, A=4565, B=1209, then i_start held high through DONE with A=B=7 → first result 3356 at k+32. The second op starts at k+33 and gives o_diff=0, o_zero=1 at k+65.
- N=8, A=0xFF, B=0x01, i_start re-pulsed mid-SHIFT with different operands → re-pulse ignored; result 0xFE at k+8.
- N=8, i_rst pulsed at cycle k+4 of an operation → outputs 0 at once and no o_done. The next start after release gives the correct result at exactly N cycles.
